// File: rtl/multicycle_control_unit.sv
// Main sequencer for the multicycle RV32I core: drives datapath selects, write strobes,
// the memory request handshake and the ALU-control op, and counts retired instructions.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// FETCH     0 | read IR at PC, PC <= PC+4 on completion
// DECODE    1 | dispatch on opcode, ALUOut <= OldPC+imm (branch/JAL target)
// MEM_ADDR  2 | ALUOut <= rs1+imm
// MEM_READ  3 | load request at ALUOut
// MEM_WB    4 | rd <= memory data
// MEM_WRITE 5 | store request at ALUOut
// EXEC_R    6 | R-type ALU op
// EXEC_I    7 | I-type ALU op
// ALU_WB    8 | rd <= ALUOut
// BRANCH    9 | PC <= target if taken
// JAL      10 | PC <= target, ALUOut <= OldPC+4
// JALR     11 | PC <= rs1+imm
// LINK     12 | ALUOut <= OldPC+4
// LUI      13 | ALUOut <= 0+imm
// AUIPC    14 | ALUOut <= OldPC+imm
// TRAP     15 | parked until reset
module multicycle_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  aluop,
    output logic [1:0]  result_src,
    output logic        instr_retired,
    output logic [31:0] instret,
    output logic        illegal,
    output logic        halted,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_LINK      = 4'd12;
    localparam logic [3:0] S_LUI       = 4'd13;
    localparam logic [3:0] S_AUIPC     = 4'd14;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [3:0]  state_q;
    logic [3:0]  state_d;
    logic [31:0] instret_q;
    logic        illegal_q;
    logic        halted_q;

    logic        req_raw;
    logic        we_raw;
    logic        irw_raw;
    logic        pcw_raw;
    logic        regw_raw;
    logic        ret_raw;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEM_ADDR;
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    OP_FENCE:  state_d = S_FETCH;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALU_WB;
            S_JALR:      state_d = S_LINK;
            S_LINK,
            S_LUI,
            S_AUIPC:     state_d = S_ALU_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    always_comb begin
        req_raw    = 1'b0;
        we_raw     = 1'b0;
        adr_src    = 1'b0;
        irw_raw    = 1'b0;
        pcw_raw    = 1'b0;
        regw_raw   = 1'b0;
        ret_raw    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        aluop      = 2'b00;
        result_src = 2'b00;
        case (state_q)
            S_FETCH: begin
                req_raw    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw_raw    = mem_ready;
                pcw_raw    = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                ret_raw   = (opcode == OP_FENCE);
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEM_READ: begin
                req_raw = 1'b1;
                adr_src = 1'b1;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                regw_raw   = 1'b1;
                ret_raw    = 1'b1;
            end
            S_MEM_WRITE: begin
                req_raw = 1'b1;
                we_raw  = 1'b1;
                adr_src = 1'b1;
                ret_raw = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                aluop     = 2'b01;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop     = 2'b10;
            end
            S_ALU_WB: begin
                regw_raw = 1'b1;
                ret_raw  = 1'b1;
            end
            S_BRANCH: begin
                pcw_raw = br_taken;
                ret_raw = 1'b1;
            end
            S_JAL: begin
                pcw_raw   = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pcw_raw    = 1'b1;
            end
            S_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    // Strobes are gated by rst so an outstanding request drops in the reset cycle itself.
    assign mem_req       = req_raw  & ~rst;
    assign mem_we        = we_raw   & ~rst;
    assign ir_write      = irw_raw  & ~rst;
    assign pc_write      = pcw_raw  & ~rst;
    assign reg_write     = regw_raw & ~rst;
    assign instr_retired = ret_raw  & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ret_raw) begin
                instret_q <= instret_q + 32'd1;
            end
            if ((state_q == S_DECODE) && (state_d == S_TRAP)) begin
                if (opcode == OP_SYSTEM) begin
                    halted_q <= 1'b1;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign state   = state_q;
    assign instret = instret_q;
    assign illegal = illegal_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: constant vector table, hand-built
// corner sequences, and random instruction streams against a cycle-count model.
module tb_multicycle_control_unit;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  aluop;
    logic [1:0]  result_src;
    logic        instr_retired;
    logic [31:0] instret;
    logic        illegal;
    logic        halted;
    logic [3:0]  state;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .aluop(aluop), .result_src(result_src),
        .instr_retired(instr_retired), .instret(instret), .illegal(illegal),
        .halted(halted), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Per-cycle trace of the most recent instruction
    logic [3:0] tr_state [64];
    logic [1:0] tr_aluop [64];
    logic [1:0] tr_rsrc  [64];
    logic       tr_req   [64];
    logic       tr_adr   [64];
    logic       tr_regw  [64];
    logic       tr_pcw   [64];
    int         wait_left;

    // Drives one instruction from its FETCH cycle; memory stalls wf cycles on the
    // fetch and wm cycles on the data access.
    task automatic run_instr(input logic [6:0] op, input logic br, input int wf, input int wm,
                             output int cycles, output int regw, output int pcw,
                             output int memwe, output bit retired, output bit trapped);
        cycles = 0; regw = 0; pcw = 0; memwe = 0; retired = 0; trapped = 0;
        wait_left = wf;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (c == 0) begin
                opcode   = op;
                br_taken = br;
            end
            if (mem_req) begin
                if (wait_left > 0) begin
                    mem_ready = 1'b0;
                    wait_left--;
                end else begin
                    mem_ready = 1'b1;
                    wait_left = wm;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            tr_state[c] = state;
            tr_aluop[c] = aluop;
            tr_rsrc[c]  = result_src;
            tr_req[c]   = mem_req;
            tr_adr[c]   = adr_src;
            tr_regw[c]  = reg_write;
            tr_pcw[c]   = pc_write;
            cycles++;
            if (reg_write) regw++;
            if (pc_write)  pcw++;
            if (mem_we)    memwe++;
            if (instr_retired) begin
                retired = 1;
                break;
            end
            if (state == 4'd15) begin
                trapped = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    // Reference model: instruction-class latency and strobe counts.
    typedef struct {
        int cycles;
        int regw;
        int pcw;
        int memwe;
        bit retire;
        bit halt;
        bit ill;
    } exp_t;

    function automatic exp_t model(input logic [6:0] op, input logic br, input int wf, input int wm);
        exp_t e;
        e.cycles = 0; e.regw = 0; e.pcw = 1; e.memwe = 0; e.retire = 1; e.halt = 0; e.ill = 0;
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin e.cycles = 4 + wf; e.regw = 1; end
            7'b1101111: begin e.cycles = 4 + wf; e.regw = 1; e.pcw = 2; end
            7'b0100011: begin e.cycles = 4 + wf + wm; e.memwe = wm + 1; end
            7'b0000011: begin e.cycles = 5 + wf + wm; e.regw = 1; end
            7'b1100111: begin e.cycles = 5 + wf; e.regw = 1; e.pcw = 2; end
            7'b1100011: begin e.cycles = 3 + wf; e.pcw = 1 + int'(br); end
            7'b0001111: e.cycles = 2 + wf;
            7'b1110011: begin e.cycles = 3 + wf; e.retire = 0; e.halt = 1; end
            default:    begin e.cycles = 3 + wf; e.retire = 0; e.ill = 1; end
        endcase
        return e;
    endfunction

    typedef struct {
        string      nm;
        logic [6:0] op;
        logic       br;
        int         wf;
        int         wm;
        int         cyc;
        int         regw;
        int         pcw;
    } vec_t;

    vec_t vecs[13];

    int cyc, rw, pw, mw;
    bit ret, trp;
    logic [31:0] base_cnt;
    logic [31:0] exp_instret;
    logic [6:0] legal_ops[10];
    int bad;

    initial begin
        vecs[0]  = '{"add",     7'b0110011, 1'b0, 0, 0, 4, 1, 1};
        vecs[1]  = '{"addi",    7'b0010011, 1'b0, 0, 0, 4, 1, 1};
        vecs[2]  = '{"lw",      7'b0000011, 1'b0, 0, 0, 5, 1, 1};
        vecs[3]  = '{"sw",      7'b0100011, 1'b0, 0, 0, 4, 0, 1};
        vecs[4]  = '{"beq_t",   7'b1100011, 1'b1, 0, 0, 3, 0, 2};
        vecs[5]  = '{"beq_nt",  7'b1100011, 1'b0, 0, 0, 3, 0, 1};
        vecs[6]  = '{"jal",     7'b1101111, 1'b0, 0, 0, 4, 1, 2};
        vecs[7]  = '{"jalr",    7'b1100111, 1'b0, 0, 0, 5, 1, 2};
        vecs[8]  = '{"lui",     7'b0110111, 1'b0, 0, 0, 4, 1, 1};
        vecs[9]  = '{"auipc",   7'b0010111, 1'b0, 0, 0, 4, 1, 1};
        vecs[10] = '{"fence",   7'b0001111, 1'b0, 0, 0, 2, 0, 1};
        vecs[11] = '{"add_fw2", 7'b0110011, 1'b0, 2, 0, 6, 1, 1};
        vecs[12] = '{"sw_mw2",  7'b0100011, 1'b0, 0, 2, 6, 0, 1};
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};

        rst = 1'b1; opcode = 7'd0; br_taken = 1'b0; mem_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1;
        check("rst_mem_req_forced", {63'd0, mem_req}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_state",   {60'd0, state}, 64'd0);
        check("rst_instret", {32'd0, instret}, 64'd0);
        check("rst_flags",   {62'd0, illegal, halted}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd1);

        // Constant vector table
        for (int i = 0; i < 13; i++) begin
            base_cnt = instret;
            run_instr(vecs[i].op, vecs[i].br, vecs[i].wf, vecs[i].wm, cyc, rw, pw, mw, ret, trp);
            check({vecs[i].nm, "_cycles"}, 64'(cyc), 64'(vecs[i].cyc));
            check({vecs[i].nm, "_regw"},   64'(rw),  64'(vecs[i].regw));
            check({vecs[i].nm, "_pcw"},    64'(pw),  64'(vecs[i].pcw));
            @(posedge clk); #1;
            check({vecs[i].nm, "_instret"}, {32'd0, instret}, {32'd0, base_cnt + 32'd1});
        end

        // Reset during an outstanding fetch
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("midfetch_req_before", {63'd0, mem_req}, 64'd1);
        rst = 1'b1;
        #1;
        check("midfetch_req_dropped", {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("midfetch_state",   {60'd0, state}, 64'd0);
        check("midfetch_instret", {32'd0, instret}, 64'd0);
        check("midfetch_req",     {63'd0, mem_req}, 64'd1);

        // ADD then ADDI
        run_instr(7'b0110011, 1'b0, 0, 0, cyc, rw, pw, mw, ret, trp);
        check("add_cycles",   64'(cyc), 64'd4);
        check("add_exec",     {58'd0, tr_state[2], tr_aluop[2]}, {58'd0, 4'd6, 2'b01});
        check("add_wb",       {59'd0, tr_state[3], tr_regw[3]}, {59'd0, 4'd8, 1'b1});
        run_instr(7'b0010011, 1'b0, 0, 0, cyc, rw, pw, mw, ret, trp);
        check("addi_cycles",  64'(cyc), 64'd4);
        check("addi_exec",    {58'd0, tr_state[2], tr_aluop[2]}, {58'd0, 4'd7, 2'b10});
        @(posedge clk); #1;
        check("add_addi_instret", {32'd0, instret}, 64'd2);

        // LW with 3 wait cycles on the data read
        run_instr(7'b0000011, 1'b0, 0, 3, cyc, rw, pw, mw, ret, trp);
        check("lw3_cycles", 64'(cyc), 64'd8);
        bad = 0;
        for (int c = 3; c < 7; c++)
            if (!(tr_state[c] == 4'd3 && tr_req[c] && tr_adr[c])) bad++;
        check("lw3_req_held", 64'(bad), 64'd0);
        check("lw3_wb", {61'd0, tr_regw[7], tr_rsrc[7]}, {61'd0, 1'b1, 2'b01});

        // JALR -> LINK -> ALU_WB
        run_instr(7'b1100111, 1'b0, 0, 0, cyc, rw, pw, mw, ret, trp);
        check("jalr_cycles", 64'(cyc), 64'd5);
        check("jalr_state",  {57'd0, tr_state[2], tr_pcw[2], tr_rsrc[2]}, {57'd0, 4'd11, 1'b1, 2'b10});
        check("jalr_link",   {60'd0, tr_state[3]}, 64'd12);
        check("jalr_wb",     {59'd0, tr_state[4], tr_regw[4]}, {59'd0, 4'd8, 1'b1});

        // Branch strobe in BRANCH state
        run_instr(7'b1100011, 1'b1, 0, 0, cyc, rw, pw, mw, ret, trp);
        check("beq_t_branch", {59'd0, tr_state[2], tr_pcw[2]}, {59'd0, 4'd9, 1'b1});
        run_instr(7'b1100011, 1'b0, 0, 0, cyc, rw, pw, mw, ret, trp);
        check("beq_nt_branch", {59'd0, tr_state[2], tr_pcw[2]}, {59'd0, 4'd9, 1'b0});

        // Random stream against the model
        do_reset();
        exp_instret = 32'd0;
        for (int i = 0; i < 200; i++) begin
            logic [6:0] op;
            logic       br;
            int         wf, wm;
            exp_t       e;
            op = legal_ops[$urandom_range(0, 9)];
            br = 1'($urandom_range(0, 1));
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            e  = model(op, br, wf, wm);
            run_instr(op, br, wf, wm, cyc, rw, pw, mw, ret, trp);
            check($sformatf("rand%0d_op%07b", i, op),
                  {32'(cyc), 8'(rw), 8'(pw), 8'(mw), 6'd0, ret, trp},
                  {32'(e.cycles), 8'(e.regw), 8'(e.pcw), 8'(e.memwe), 6'd0, e.retire, 1'b0});
            if (e.retire) exp_instret = exp_instret + 32'd1;
        end
        @(posedge clk); #1;
        check("rand_instret", {32'd0, instret}, {32'd0, exp_instret});

        // Illegal opcode trap
        do_reset();
        run_instr(7'b0000000, 1'b0, 1, 0, cyc, rw, pw, mw, ret, trp);
        check("ill_trapped", {62'd0, trp, ret}, {62'd0, 1'b1, 1'b0});
        check("ill_cycles",  64'(cyc), 64'(model(7'b0000000, 1'b0, 1, 0).cycles));
        check("ill_flags",   {62'd0, illegal, halted}, {62'd0, 1'b1, 1'b0});
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            if (mem_req || instr_retired || state != 4'd15) bad++;
        end
        check("ill_parked", 64'(bad), 64'd0);
        check("ill_instret", {32'd0, instret}, 64'd0);

        // ECALL halt
        do_reset();
        #1;
        check("rst_clears_illegal", {62'd0, illegal, halted}, 64'd0);
        run_instr(7'b1110011, 1'b0, 0, 0, cyc, rw, pw, mw, ret, trp);
        check("ecall_flags", {61'd0, trp, illegal, halted}, {61'd0, 1'b1, 1'b0, 1'b1});

        // Counter wrap
        do_reset();
        dut.instret_q = 32'hFFFF_FFFF;
        run_instr(7'b0110111, 1'b0, 0, 0, cyc, rw, pw, mw, ret, trp);
        check("wrap_before", {32'd0, instret}, 64'hFFFF_FFFF);
        @(posedge clk); #1;
        check("wrap_after", {32'd0, instret}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Main sequencer for the multicycle RV32I core.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects, register/PC/IR write strobes, the memory request handshake, and the 2-bit `aluop` consumed by the ALU control unit.
- Also counts retired instructions.

## Interface
Parameters: none.
- `clk` in 1 — core clock.
- `rst` in 1 — reset, synchronous, active-high; one clock only.
- `opcode` in 7 — IR[6:0], valid from DECODE onward.
- `br_taken` in 1 — external branch comparator result for the current IR (funct3-qualified).
- `mem_ready` in 1 — memory completes the current request this cycle.
- `mem_req` out 1 — memory request, held until `mem_ready`.
- `mem_we` out 1 — request is a write.
- `adr_src` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `ir_write` out 1 — latch IR and OldPC.
- `pc_write` out 1 — PC <= result bus.
- `reg_write` out 1 — rd <= result bus.
- `alu_src_a` out 2 — 00 PC, 01 OldPC, 10 A (rs1), 11 zero.
- `alu_src_b` out 2 — 00 B (rs2), 01 imm, 10 constant 4.
- `aluop` out 2 — 00 ADD, 01 R-type decode, 10 I-type decode.
- `result_src` out 2 — 00 ALUOut register, 01 memory data, 10 ALU result (direct).
- `instr_retired` out 1 — one-cycle pulse when an instruction completes.
- `instret` out 32 — retired-instruction count.
- `illegal` out 1 — sticky: unknown opcode trapped.
- `halted` out 1 — sticky: ECALL/EBREAK reached.
- `state` out 4 — current state encoding, for debug.

## Operation
State encodings, with the outputs each state asserts. Unlisted outputs are 0 and selects are 00.

- **FETCH (0)**
  - mem_req; adr_src=0; src_a=00, src_b=10, aluop=00, result_src=10.
  - ir_write and pc_write = mem_ready.
  - Exit to DECODE on mem_ready.
- **DECODE (1)**
  - src_a=01, src_b=01, aluop=00; ALUOut captures the branch/JAL target.
  - Next state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - 0001111 (FENCE) → FETCH, with instr_retired
    - 1110011 → TRAP, setting halted
    - any other → TRAP, setting illegal
- **MEM_ADDR (2)**: src_a=10, src_b=01, aluop=00. Next: MEM_READ if opcode[5]=0, else MEM_WRITE.
- **MEM_READ (3)**: mem_req, adr_src=1. Exit to MEM_WB on mem_ready.
- **MEM_WB (4)**: result_src=01, reg_write, instr_retired. Next: FETCH.
- **MEM_WRITE (5)**: mem_req, mem_we, adr_src=1. On mem_ready: instr_retired and go to FETCH.
- **EXEC_R (6)**: src_a=10, src_b=00, aluop=01. Next: ALU_WB.
- **EXEC_I (7)**: src_a=10, src_b=01, aluop=10. Next: ALU_WB.
- **ALU_WB (8)**: result_src=00, reg_write, instr_retired. Next: FETCH.
- **BRANCH (9)**: result_src=00, pc_write=br_taken, instr_retired. Next: FETCH.
- **JAL (10)**
  - result_src=00, pc_write (target from DECODE).
  - src_a=01, src_b=10, aluop=00; ALUOut becomes the link value.
  - Next: ALU_WB.
- **JALR (11)**
  - src_a=10, src_b=01, aluop=00, result_src=10, pc_write.
  - LSB clearing is done in the datapath.
  - Next: LINK.
- **LINK (12)**: src_a=01, src_b=10, aluop=00. Next: ALU_WB.
- **LUI (13)**: src_a=11, src_b=01, aluop=00. Next: ALU_WB.
- **AUIPC (14)**: src_a=01, src_b=01, aluop=00. Next: ALU_WB.
- **TRAP (15)**: all strobes 0. Remains here until `rst`.

Retire counter:
- `instret` increments by 1 on every `instr_retired`.
- Wraps from 0xFFFFFFFF to 0 without any flag.

## Timing
Reset:
- While `rst`=1, mem_req, mem_we, ir_write, pc_write, reg_write and instr_retired are forced to 0.
- On the reset edge: state=FETCH, instret=0, illegal=0, halted=0.
- Reset during an outstanding request abandons it; `mem_req` drops in the same cycle.

Memory handshake:
- mem_req, mem_we and adr_src stay stable until the cycle in which mem_ready=1.
- The transfer completes in that cycle; the state advances on the following edge.
- mem_ready is ignored when mem_req=0.

Latency with zero-wait memory (mem_ready held high):

| Instruction class | Cycles |
|---|---|
| R-type, I-type, store, JAL, LUI, AUIPC | 4 |
| Load, JALR | 5 |
| Branch | 3 |
| FENCE | 2 |

- Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.

Other timing rules:
- instr_retired is exactly one cycle per instruction. It is never asserted in TRAP or for a trapped instruction.
- `illegal` and `halted` rise on the edge that enters TRAP.

## Test plan
- **Reset mid-fetch.** Assert rst in FETCH with mem_ready=0.
  - mem_req=0 in that cycle.
  - After release: state=0, instret=0, mem_req=1.
- **ADD then ADDI, zero-wait.**
  - Each takes 4 cycles; aluop=01 in EXEC_R and 10 in EXEC_I.
  - reg_write pulses in ALU_WB; instret=2.
- **LW with 3 wait cycles in MEM_READ.**
  - mem_req and adr_src=1 held for 4 cycles.
  - 8 cycles total; reg_write with result_src=01.
- **BEQ.**
  - br_taken=1: pc_write in BRANCH, 3 cycles.
  - br_taken=0: pc_write=0 in BRANCH.
  - instret increments in both cases.
- **JALR.**
  - Sequence JALR (pc_write, result_src=10) → LINK → ALU_WB (reg_write).
  - 5 cycles.
- **Trap and counter wrap.**
  - opcode 0000000 → TRAP, illegal=1, no further mem_req.
  - Separately, force instret=0xFFFFFFFF and retire one instruction → instret=0.
